// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide, UNROLL bits per cycle. Optional early-out path: define MULDIV_EARLY_OUT_EN.
module muldiv_iter_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int N     = XLEN / UNROLL;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(N);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t state, state_nxt;

    logic [2:0]       f3_q;
    logic [XLEN:0]    hi_q, hi_nxt;   // product high half / partial remainder
    logic [XLEN-1:0]  lo_q, lo_nxt;   // multiplier or dividend, shifted out as bits retire
    logic [XLEN:0]    opb_q;          // multiplicand or divisor magnitude
    logic             neg_quo, neg_rem;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             a_neg, b_neg;
    logic [XLEN:0]    mag_a, mag_b;
    logic             div_zero, div_ovf;
    logic             mul_trivial, div_trivial;
    logic [XLEN:0]    trial;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]  quo, rem, fix_result;

    assign accept = in_valid && !flush && (state == S_IDLE);

    // Operand decode for the accept edge: magnitudes, signs, special cases.
    always_comb begin
        a_neg    = in_a[XLEN-1] && ((in_funct3 == 3'd1) || (in_funct3 == 3'd2) ||
                                    (in_funct3 == 3'd4) || (in_funct3 == 3'd6));
        b_neg    = in_b[XLEN-1] && ((in_funct3 == 3'd1) || (in_funct3 == 3'd4) ||
                                    (in_funct3 == 3'd6));
        mag_a    = a_neg ? -{1'b1, in_a} : {1'b0, in_a};
        mag_b    = b_neg ? -{1'b1, in_b} : {1'b0, in_b};
        div_zero = in_funct3[2] && (in_b == '0);
        div_ovf  = ((in_funct3 == 3'd4) || (in_funct3 == 3'd6)) &&
                   (in_a == MOST_NEG) && (in_b == '1);
`ifdef MULDIV_EARLY_OUT_EN
        mul_trivial = !in_funct3[2] &&
                      ((mag_a == '0) || (mag_b == '0) || (mag_b == (XLEN+1)'(1)));
        div_trivial = in_funct3[2] && !div_zero && !div_ovf && (mag_a < mag_b);
`else
        mul_trivial = 1'b0;
        div_trivial = 1'b0;
`endif
    end

    // UNROLL iterations of shift-add (multiply) or restoring subtract (divide).
    always_comb begin
        hi_nxt = hi_q;
        lo_nxt = lo_q;
        trial  = '0;
        for (int u = 0; u < UNROLL; u++) begin
            if (f3_q[2]) begin
                trial  = {hi_nxt[XLEN-1:0], lo_nxt[XLEN-1]};
                lo_nxt = {lo_nxt[XLEN-2:0], 1'b0};
                if (trial >= opb_q) begin
                    hi_nxt    = trial - opb_q;
                    lo_nxt[0] = 1'b1;
                end else begin
                    hi_nxt = trial;
                end
            end else begin
                trial  = lo_nxt[0] ? ({1'b0, hi_nxt[XLEN-1:0]} + opb_q)
                                   : {1'b0, hi_nxt[XLEN-1:0]};
                lo_nxt = {trial[0], lo_nxt[XLEN-1:1]};
                hi_nxt = {1'b0, trial[XLEN:1]};
            end
        end
    end

    // Sign fix-up and half/quotient/remainder select.
    always_comb begin
        prod = {hi_q[XLEN-1:0], lo_q};
        if (neg_quo) begin
            prod = -prod;
        end
        quo = neg_quo ? -lo_q : lo_q;
        rem = neg_rem ? -hi_q[XLEN-1:0] : hi_q[XLEN-1:0];
        case (f3_q)
            3'd0:                fix_result = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fix_result = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:          fix_result = quo;
            default:             fix_result = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output and next-state is given a default before the case so
    // that no path leaves a value unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (div_zero || div_ovf) begin
                        state_nxt = S_FIX;
                    end else if (in_funct3[2]) begin
                        state_nxt = S_DIV;
                    end else begin
                        state_nxt = S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q == LAST) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX:  state_nxt = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            f3_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            opb_q      <= '0;
            neg_quo    <= 1'b0;
            neg_rem    <= 1'b0;
            cnt_q      <= '0;
            out_result <= '0;
            out_tag    <= '0;
        end else begin
            if (accept) begin
                f3_q    <= in_funct3;
                out_tag <= in_tag;
                cnt_q   <= '0;
                hi_q    <= '0;
                neg_quo <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                // Special cases preload the final quotient/remainder so FIX passes them through.
                if (div_zero) begin
                    lo_q    <= '1;
                    hi_q    <= {1'b0, in_a};
                    neg_quo <= 1'b0;
                    neg_rem <= 1'b0;
                end else if (div_ovf) begin
                    lo_q    <= in_a;
                    neg_quo <= 1'b0;
                    neg_rem <= 1'b0;
                end else if (mul_trivial) begin
                    cnt_q <= LAST;
                    lo_q  <= (mag_b == '0) ? '0 : mag_a[XLEN-1:0];
                end else if (div_trivial) begin
                    cnt_q <= LAST;
                    lo_q  <= '0;
                    hi_q  <= mag_a;
                end else if (in_funct3[2]) begin
                    lo_q  <= mag_a[XLEN-1:0];
                    opb_q <= mag_b;
                end else begin
                    lo_q  <= mag_b[XLEN-1:0];
                    opb_q <= mag_a;
                end
            end else if (((state == S_MUL) || (state == S_DIV)) && (cnt_q != LAST)) begin
                hi_q  <= hi_nxt;
                lo_q  <= lo_nxt;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (state == S_FIX) begin
                out_result <= fix_result;
            end
        end
    end

endmodule
